// File: rtl/ft245_pkg.sv
// Shared constants and state encoding for the FT245 transmit drain.
package ft245_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned CNT_W         = 16;
  localparam int unsigned TIMER_W       = 4;
  localparam int unsigned TIMER_MAX     = 15;

  localparam int unsigned SETUP_CYC_DEF = 1;
  localparam int unsigned WR_CYC_DEF    = 3;
  localparam int unsigned HOLD_CYC_DEF  = 1;
  localparam int unsigned WAITHI_TO     = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETUP  = 3'd3,
    ST_STROBE = 3'd4,
    ST_HOLD   = 3'd5,
    ST_WAITHI = 3'd6
  } state_t;

  // Timer reload value for a phase lasting cyc cycles (counts down to zero).
  function automatic logic [TIMER_W-1:0] timer_load(input int unsigned cyc);
    return TIMER_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/sync2_n.sv
// Two-flop synchronizer with a parameterized reset value.
module sync2_n #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/ft245_tx_drain.sv
// Drains bytes from an async FIFO read port into an FT245 write interface,
// one byte per handshake, with a shared phase timer and a sent-byte counter.
module ft245_tx_drain
  import ft245_pkg::*;
#(
  parameter int unsigned SETUP_CYC = SETUP_CYC_DEF,
  parameter int unsigned WR_CYC    = WR_CYC_DEF,
  parameter int unsigned HOLD_CYC  = HOLD_CYC_DEF
) (
  input  logic              rclk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              rd_en,
  input  logic              txe_n,
  output logic [DATA_W-1:0] ft_d,
  output logic              ft_oe,
  output logic              wr,
  output logic              busy,
  output logic [CNT_W-1:0]  tx_count
);

  if (SETUP_CYC < 1 || SETUP_CYC > TIMER_MAX) begin : g_bad_setup
    $error("SETUP_CYC must be within 1..15");
  end
  if (WR_CYC < 1 || WR_CYC > TIMER_MAX) begin : g_bad_wr
    $error("WR_CYC must be within 1..15");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > TIMER_MAX) begin : g_bad_hold
    $error("HOLD_CYC must be within 1..15");
  end

  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    count_q;
  logic                cnt_inc;
  logic                rd_en_d, wr_d, oe_d, busy_d;
  logic                txe_s;

  // TXE# preset to "busy" so nothing is fetched until the real level arrives.
  sync2_n #(.RST_VAL(1'b1)) u_txe_sync (
    .clk   (rclk),
    .rst_n (rst_n),
    .d     (txe_n),
    .q     (txe_s)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    data_d  = data_q;
    cnt_inc = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty && !txe_s) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        data_d  = fifo_rdata;
        state_d = ST_SETUP;
        timer_d = timer_load(SETUP_CYC);
      end
      ST_SETUP: begin
        if (timer_q == '0) begin
          state_d = ST_STROBE;
          timer_d = timer_load(WR_CYC);
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_STROBE: begin
        if (timer_q == '0) begin
          state_d = ST_HOLD;
          timer_d = timer_load(HOLD_CYC);
          cnt_inc = 1'b1;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_HOLD: begin
        if (timer_q == '0) begin
          state_d = ST_WAITHI;
          timer_d = timer_load(WAITHI_TO);
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_WAITHI: begin
        // Wait for the chip to show busy so a stale TXE# cannot start a new byte.
        if (txe_s || timer_q == '0) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    rd_en_d = (state_d == ST_FETCH);
    wr_d    = (state_d == ST_STROBE);
    oe_d    = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      data_q  <= '0;
      count_q <= '0;
      rd_en   <= 1'b0;
      wr      <= 1'b0;
      ft_oe   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      rd_en   <= rd_en_d;
      wr      <= wr_d;
      ft_oe   <= oe_d;
      busy    <= busy_d;
      if (cnt_inc) count_q <= count_q + CNT_W'(1);
    end
  end

  assign ft_d     = data_q;
  assign tx_count = count_q;

endmodule

// File: doc/ft245_tx_drain.md
FT245_TX_DRAIN -- requirements
Module: ft245_tx_drain

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1: rclk cycles that data is driven before wr rises.
REQ-002 SHALL have parameter WR_CYC, default 3: rclk cycles that wr is held high (>=50 ns at 48 MHz).
REQ-003 SHALL have parameter HOLD_CYC, default 1: rclk cycles that data stays driven after wr falls.
REQ-004 Ports, in this order:
- rclk  in  1  single clock; read-side clock of the async FIFO.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  drain permitted while high.
- fifo_empty  in  1  registered empty flag from the async comparator, rclk domain.
- fifo_rdata  in  8  FIFO RAM read data, valid one cycle after rd_en.
- rd_en  out  1  one-cycle pop strobe; advances the FIFO read pointer.
- txe_n  in  1  FT245 TXE#, asynchronous; low = chip accepts a byte.
- ft_d  out  8  FT245 data bus value.
- ft_oe  out  1  drive enable for the ft_d pad tristate.
- wr  out  1  FT245 WR strobe; byte latched on falling edge.
- busy  out  1  high in any state other than IDLE.
- tx_count  out  16  bytes written to FT245 since reset, wraps.

Function
REQ-005 SHALL pass txe_n through a 2-flop synchronizer, giving txe_s (2-cycle latency); only txe_s is used internally.
REQ-006 FSM states SHALL be: IDLE, FETCH, LOAD, SETUP, STROBE, HOLD, WAITHI.
REQ-007 IDLE -> FETCH when enable=1, fifo_empty=0 and txe_s=0, all sampled in the same cycle; otherwise stay in IDLE.
REQ-008 FETCH SHALL assert rd_en for exactly one cycle, then go to LOAD.
REQ-009 LOAD SHALL capture fifo_rdata into the data register, set ft_oe=1, then go to SETUP.
REQ-010 SETUP SHALL last SETUP_CYC cycles with wr=0, then go to STROBE.
REQ-011 STROBE SHALL last WR_CYC cycles with wr=1, then go to HOLD.
REQ-012 On the STROBE->HOLD transition, tx_count SHALL increment by 1, modulo 2^16.
REQ-013 HOLD SHALL last HOLD_CYC cycles with wr=0 and ft_oe=1, then clear ft_oe and go to WAITHI.
REQ-014 WAITHI SHALL wait until txe_s=1 (chip busy acknowledged) or 8 cycles have elapsed, then go to IDLE; this blocks back-to-back writes on a stale TXE#.
REQ-015 ft_d SHALL equal the data register at all times and SHALL change only in LOAD.
REQ-016 A single 4-bit down-counter SHALL time SETUP, STROBE, HOLD and WAITHI; parameters SHALL be checked 1..15 at elaboration.
REQ-017 enable deasserted mid-transfer SHALL NOT abort the transfer; the FSM completes through WAITHI and then holds in IDLE.
REQ-018 txe_s rising during SETUP or STROBE SHALL be ignored; the started byte always completes.
REQ-019 fifo_empty is pessimistic, so its deassertion may lag; the block SHALL never assert rd_en while fifo_empty=1.
REQ-020 Throughput with defaults and immediate TXE# response: one byte per at most 18 cycles.

Reset
REQ-021 While rst_n=0: state=IDLE, rd_en=0, wr=0, ft_oe=0, ft_d=0, tx_count=0, busy=0, timer=0, and both synchronizer flops=1 (chip busy).
REQ-022 Reset asserted mid-STROBE SHALL drop wr asynchronously; that byte is not counted.
REQ-023 After rst_n rises, no FETCH SHALL occur for at least 2 cycles, because the synchronizer preset to 1 must flush first.

Structure
REQ-024 The shared package (ft245_pkg) SHALL hold the state encoding (3-bit), the SETUP/WR/HOLD defaults, and the WAITHI timeout constant 8.
REQ-025 One sub-module SHALL be used: sync2_n, a 2-flop synchronizer with parameterized reset value; the FSM, timer and counter stay in this module.

Verification
REQ-026 FIFO holds 0xA5, txe_n=0, enable=1 -> one rd_en pulse; ft_d=0xA5 before wr rises; wr high for 3 cycles; tx_count=1.
REQ-027 Push 0x01..0x04 with txe_n toggling high 2 cycles after each wr fall -> 4 bytes out in order, 4 rd_en pulses, tx_count=4.
REQ-028 txe_n held at 1 with FIFO non-empty -> no rd_en, wr stays 0, busy=0 indefinitely.
REQ-029 txe_n never rises after a write -> WAITHI times out after 8 cycles; next byte proceeds.
REQ-030 rst_n pulled low in the 2nd STROBE cycle -> wr=0 immediately, tx_count=0, state IDLE; first rd_en no earlier than 3 cycles after release.
REQ-031 Preload tx_count to 0xFFFF via 65535 writes (or force) -> next write gives tx_count=0x0000.
